// File: rtl/tetris_pkg.sv
// Shared constants for the Tetris input path: pin indices and channel FSM state codes.
// Used by tetris_debounce_ch and tetris_input_conditioner (see TETRIS_AUTOREPEAT_EN there).
package tetris_pkg;

    localparam int BTN_RIGHT  = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_ROTATE = 3;
    localparam int SW_RUN     = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_HELD   = 3'd2;
    localparam logic [2:0] ST_REPEAT = 3'd3;
    localparam logic [2:0] ST_REL    = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tetris_debounce_ch.sv
// One input channel: 2-flop synchroniser, debounce/repeat FSM, saturating counter.
// Hold-to-repeat exists only when TETRIS_AUTOREPEAT_EN is defined and REPEAT_ALLOW is set.
module tetris_debounce_ch
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY_CYCLES = 25_000_000,
    parameter int REPEAT_RATE_CYCLES  = 5_000_000,
    parameter bit REPEAT_ALLOW        = 1'b0
) (
    input  logic w_pixclk,
    input  logic w_reset_n,
    input  logic i_raw,
    output logic o_fire,
    output logic o_level
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE_CYCLES - 1);
`ifdef TETRIS_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif
    localparam bit REP_EN = AUTOREPEAT && REPEAT_ALLOW;

    logic [1:0]       r_sync;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_s;
    logic             w_fire;

    assign w_s       = r_sync[1];
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt = ST_ARM;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ARM: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_fire      = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            // Without repeat support HELD just waits for the release.
            ST_HELD: begin
                if (!w_s) begin
                    w_state_nxt = ST_REL;
                    w_cnt_nxt   = '0;
                end else if (REP_EN) begin
                    if (r_cnt == DLY_LAST) begin
                        w_state_nxt = ST_REPEAT;
                        w_cnt_nxt   = '0;
                        w_fire      = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            ST_REPEAT: begin
                if (!w_s) begin
                    w_state_nxt = ST_REL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == RATE_LAST) begin
                    w_cnt_nxt = '0;
                    w_fire    = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            // A bounce back high during release is treated as still held, no new pulse.
            ST_REL: begin
                if (w_s) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge w_pixclk or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_sync  <= 2'b00;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_fire  = w_fire;
    assign o_level = (r_state == ST_HELD) || (r_state == ST_REPEAT) || (r_state == ST_REL);

endmodule

// File: rtl/tetris_input_conditioner.sv
// Board switch/button conditioner feeding game_logic_fsm with clean one-cycle pulses.
// Define TETRIS_AUTOREPEAT_EN to enable hold-to-repeat on right/down/left.
module tetris_input_conditioner
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY_CYCLES = 25_000_000,
    parameter int REPEAT_RATE_CYCLES  = 5_000_000
) (
    input  logic       w_pixclk,
    input  logic       w_reset_n,
    input  logic [3:0] i_sw,
    input  logic [3:0] i_btn,
    output logic       o_start,
    output logic       o_right,
    output logic       o_down,
    output logic       o_left,
    output logic       o_rotate,
    output logic [3:0] o_sw_level,
    output logic [3:0] o_btn_level
);

    logic [3:0] w_sw_fire;
    logic [3:0] w_btn_fire;
    logic       w_run;
    logic       w_lr_clash;
    logic       w_unused_sw_fire;
    logic       r_start, r_right, r_down, r_left, r_rotate;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        tetris_debounce_ch #(
            .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
            .REPEAT_ALLOW       (1'b0)
        ) u_sw (
            .w_pixclk (w_pixclk),
            .w_reset_n(w_reset_n),
            .i_raw    (i_sw[i]),
            .o_fire   (w_sw_fire[i]),
            .o_level  (o_sw_level[i])
        );

        tetris_debounce_ch #(
            .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
            .REPEAT_ALLOW       (1'(i != BTN_ROTATE))
        ) u_btn (
            .w_pixclk (w_pixclk),
            .w_reset_n(w_reset_n),
            .i_raw    (i_btn[i]),
            .o_fire   (w_btn_fire[i]),
            .o_level  (o_btn_level[i])
        );
    end

    assign w_unused_sw_fire = ^w_sw_fire[2:0];
    assign w_run            = o_sw_level[SW_RUN];
    assign w_lr_clash       = w_btn_fire[BTN_RIGHT] & w_btn_fire[BTN_LEFT];

    // Moves only reach the game while it runs; simultaneous left+right cancel out.
    always_ff @(posedge w_pixclk or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_start  <= 1'b0;
            r_right  <= 1'b0;
            r_down   <= 1'b0;
            r_left   <= 1'b0;
            r_rotate <= 1'b0;
        end else begin
            r_start  <= w_sw_fire[SW_RUN];
            r_right  <= w_run & w_btn_fire[BTN_RIGHT] & ~w_lr_clash;
            r_left   <= w_run & w_btn_fire[BTN_LEFT] & ~w_lr_clash;
            r_down   <= w_run & w_btn_fire[BTN_DOWN];
            r_rotate <= w_run & w_btn_fire[BTN_ROTATE];
        end
    end

    assign o_start  = r_start;
    assign o_right  = r_right;
    assign o_down   = r_down;
    assign o_left   = r_left;
    assign o_rotate = r_rotate;

endmodule

// File: tb/tb_tetris_input_conditioner.sv
// Directed bench for tetris_input_conditioner with DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// Expectations adapt to whether TETRIS_AUTOREPEAT_EN is defined.
module tb_tetris_input_conditioner;

    logic       w_pixclk = 1'b0;
    logic       w_reset_n = 1'b0;
    logic [3:0] i_sw = 4'b0000;
    logic [3:0] i_btn = 4'b0000;
    logic       o_start, o_right, o_down, o_left, o_rotate;
    logic [3:0] o_sw_level, o_btn_level;

    int checks = 0;
    int errors = 0;

`ifdef TETRIS_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    tetris_input_conditioner #(
        .DEBOUNCE_CYCLES    (4),
        .REPEAT_DELAY_CYCLES(10),
        .REPEAT_RATE_CYCLES (3)
    ) dut (
        .w_pixclk   (w_pixclk),
        .w_reset_n  (w_reset_n),
        .i_sw       (i_sw),
        .i_btn      (i_btn),
        .o_start    (o_start),
        .o_right    (o_right),
        .o_down     (o_down),
        .o_left     (o_left),
        .o_rotate   (o_rotate),
        .o_sw_level (o_sw_level),
        .o_btn_level(o_btn_level)
    );

    always #5 w_pixclk = ~w_pixclk;

    task automatic tick();
        @(posedge w_pixclk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        w_reset_n = 1'b0;
        i_sw = 4'b0000;
        i_btn = 4'b0000;
        wait_cycles(3);
        obs = {o_start, o_right, o_down, o_left, o_rotate, o_sw_level, o_btn_level};
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 13'd0);
        end
        w_reset_n = 1'b1;
        wait_cycles(3);
        obs = {o_start, o_right, o_down, o_left, o_rotate, o_sw_level, o_btn_level};
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %b expected %b", obs, 13'd0);
        end
    endtask

    task automatic test_start();
        logic exp_p, exp_l;
        i_sw[3] = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            tick();
            exp_p = (e == 6);
            exp_l = (e >= 6);
            checks++;
            if (o_start !== exp_p) begin
                errors++;
                $display("[TB] FAIL start_pulse: edge %0d got %b expected %b", e, o_start, exp_p);
            end
            checks++;
            if (o_sw_level[3] !== exp_l) begin
                errors++;
                $display("[TB] FAIL start_level: edge %0d got %b expected %b", e, o_sw_level[3], exp_l);
            end
        end
    endtask

    task automatic test_bounce();
        logic [6:0] pat;
        pat = 7'b1110111;
        i_btn[2] = pat[0];
        for (int e = 0; e <= 20; e++) begin
            tick();
            checks++;
            if (o_left !== 1'b0 || o_btn_level[2] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bounce: edge %0d got left=%b level=%b expected 0/0", e, o_left, o_btn_level[2]);
            end
            i_btn[2] = (e + 1 <= 6) ? pat[e + 1] : 1'b0;
        end
    endtask

    task automatic test_autorepeat();
        logic exp_p, exp_l;
        i_btn[1] = 1'b1;
        for (int e = 0; e <= 55; e++) begin
            tick();
            exp_p = (e == 6) || (AUTOREP && e >= 16 && e <= 40 && ((e - 16) % 3 == 0));
            exp_l = (e >= 6) && (e < 46);
            checks++;
            if (o_down !== exp_p) begin
                errors++;
                $display("[TB] FAIL down_pulse: edge %0d got %b expected %b", e, o_down, exp_p);
            end
            checks++;
            if (o_btn_level[1] !== exp_l) begin
                errors++;
                $display("[TB] FAIL down_level: edge %0d got %b expected %b", e, o_btn_level[1], exp_l);
            end
            checks++;
            if ({o_right, o_left, o_rotate} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL down_crosstalk: edge %0d got %b expected 000", e, {o_right, o_left, o_rotate});
            end
            if (e == 39) i_btn[1] = 1'b0;
        end
    endtask

    task automatic test_rotate();
        logic exp_p, exp_l;
        i_btn[3] = 1'b1;
        for (int e = 0; e <= 55; e++) begin
            tick();
            exp_p = (e == 6);
            exp_l = (e >= 6) && (e < 46);
            checks++;
            if (o_rotate !== exp_p) begin
                errors++;
                $display("[TB] FAIL rotate_pulse: edge %0d got %b expected %b", e, o_rotate, exp_p);
            end
            checks++;
            if (o_btn_level[3] !== exp_l) begin
                errors++;
                $display("[TB] FAIL rotate_level: edge %0d got %b expected %b", e, o_btn_level[3], exp_l);
            end
            if (e == 39) i_btn[3] = 1'b0;
        end
    endtask

    task automatic test_gating();
        logic exp;
        i_sw[3] = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            exp = (e < 6);
            checks++;
            if (o_sw_level[3] !== exp) begin
                errors++;
                $display("[TB] FAIL run_release: edge %0d got %b expected %b", e, o_sw_level[3], exp);
            end
        end
        i_btn[0] = 1'b1;
        for (int e = 0; e <= 19; e++) begin
            tick();
            exp = (e >= 6);
            checks++;
            if (o_right !== 1'b0 || o_btn_level[0] !== exp) begin
                errors++;
                $display("[TB] FAIL gated_right: edge %0d got right=%b level=%b expected 0/%b", e, o_right, o_btn_level[0], exp);
            end
            if (e == 19) i_btn[0] = 1'b0;
        end
        wait_cycles(10);
        i_sw[3] = 1'b1;
        wait_cycles(10);
        i_btn[0] = 1'b1;
        for (int e = 0; e <= 19; e++) begin
            tick();
            exp = (e == 6) || (AUTOREP && (e == 16 || e == 19));
            checks++;
            if (o_right !== exp) begin
                errors++;
                $display("[TB] FAIL right_pulse: edge %0d got %b expected %b", e, o_right, exp);
            end
            if (e == 19) i_btn[0] = 1'b0;
        end
        wait_cycles(10);
        i_btn[0] = 1'b1;
        i_btn[2] = 1'b1;
        for (int e = 0; e <= 19; e++) begin
            tick();
            exp = (e >= 6);
            checks++;
            if ({o_right, o_left} !== 2'b00 || {o_btn_level[0], o_btn_level[2]} !== {exp, exp}) begin
                errors++;
                $display("[TB] FAIL lr_conflict: edge %0d got r/l=%b levels=%b expected 00/%b%b", e, {o_right, o_left}, {o_btn_level[0], o_btn_level[2]}, exp, exp);
            end
            if (e == 19) begin
                i_btn[0] = 1'b0;
                i_btn[2] = 1'b0;
            end
        end
        wait_cycles(10);
    endtask

    task automatic test_reset_mid();
        logic [12:0] obs;
        logic exp_p, exp_l;
        i_btn[1] = 1'b1;
        for (int e = 0; e <= 16; e++) begin
            tick();
        end
        checks++;
        if (o_btn_level[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_level: got %b expected 1", o_btn_level[1]);
        end
        w_reset_n = 1'b0;
        #1;
        obs = {o_start, o_right, o_down, o_left, o_rotate, o_sw_level, o_btn_level};
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b expected %b", obs, 13'd0);
        end
        wait_cycles(2);
        obs = {o_start, o_right, o_down, o_left, o_rotate, o_sw_level, o_btn_level};
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_held: got %b expected %b", obs, 13'd0);
        end
        w_reset_n = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            tick();
            exp_p = (e == 6);
            exp_l = (e >= 6);
            checks++;
            if (o_start !== exp_p) begin
                errors++;
                $display("[TB] FAIL post_reset_start: edge %0d got %b expected %b", e, o_start, exp_p);
            end
            checks++;
            if (o_btn_level[1] !== exp_l || o_sw_level[3] !== exp_l) begin
                errors++;
                $display("[TB] FAIL post_reset_level: edge %0d got btn1=%b sw3=%b expected %b", e, o_btn_level[1], o_sw_level[3], exp_l);
            end
        end
        i_btn[1] = 1'b0;
        wait_cycles(10);
    endtask

    initial begin
        test_reset();
        test_start();
        test_bounce();
        test_autorepeat();
        test_rotate();
        test_gating();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tetris_input_conditioner.md
# tetris_input_conditioner

Conditions raw board switches and push-buttons into clean, single-cycle control pulses for the Tetris game logic FSM. The block sits between the board pins and `game_logic_fsm`, replacing the current bare one-flop capture of `sw`/`btn`. Each input is synchronised, debounced and edge-detected. Movement buttons get an optional hold-to-repeat behaviour.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000 — consecutive stable samples required to accept a level change; must be ≥1.
- REPEAT_DELAY_CYCLES, 25_000_000 — hold time after the first pulse before auto-repeat begins; must be ≥1.
- REPEAT_RATE_CYCLES, 5_000_000 — period between auto-repeat pulses; must be ≥1.

Ports:
- w_pixclk  in  1  system clock.
- w_reset_n  in  1  reset; asynchronous, active-low.
- i_sw  in  4  raw switches; bit 3 = game start/run.
- i_btn  in  4  raw buttons; 0 = right, 1 = down, 2 = left, 3 = rotate.
- o_start  out  1  one-cycle pulse on accepted rising edge of sw[3].
- o_right, o_down, o_left, o_rotate  out  1 each  one-cycle move pulses.
- o_sw_level  out  4  debounced switch levels.
- o_btn_level  out  4  debounced button levels.

## Operation
- Each of the 8 inputs passes through a 2-flop synchroniser, giving `s`. The synchroniser flops reset to 0.
- Each input has its own channel FSM. States:
  - IDLE: accepted level is 0. If s=1, go to ARM and set cnt=0.
  - ARM: if s=0, go to IDLE. Otherwise increment cnt. When cnt reaches DEBOUNCE_CYCLES-1 with s=1, go to HELD and emit one pulse.
  - HELD: accepted level is 1; cnt counts the repeat delay. If s=0, go to REL with cnt=0. If cnt reaches REPEAT_DELAY_CYCLES-1, emit a pulse and go to REPEAT with cnt=0.
  - REPEAT: if s=0, go to REL. If cnt reaches REPEAT_RATE_CYCLES-1, emit a pulse and set cnt=0.
  - REL: any s=1 returns to HELD with cnt=0 and no pulse. After DEBOUNCE_CYCLES consecutive s=0 samples, go to IDLE.
- Auto-repeat (HELD→REPEAT) applies only to right, down and left. The rotate and switch channels stay in HELD until release.
- Debounced level = 1 in HELD, REPEAT and REL. Otherwise 0.
- Counter width is $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)+1). Counters saturate and never wrap.
- o_start = sw[3] channel pulse.
- Move pulses are gated by o_sw_level[3]. While the game is not running, no move pulses are output, but the channel FSMs still run.
- If right and left pulse in the same cycle, both are suppressed. Down and rotate are unaffected by this rule.
- All pulse outputs are registered.

## Timing
- Reset values: all outputs 0, all FSMs in IDLE, counters 0. Reset is asynchronous, including mid-operation. A press in progress is discarded.
- A button still held when reset is released produces exactly one pulse after the normal latency.
- Press latency: if raw input is first sampled high at edge k and stays high, the pulse is high for exactly the one cycle after edge k+2+DEBOUNCE_CYCLES.
- Level latency: the debounced level rises at that same edge. It falls DEBOUNCE_CYCLES+2 edges after release is first sampled, provided the release is stable.
- First repeat pulse: REPEAT_DELAY_CYCLES edges after the first pulse. Subsequent repeats every REPEAT_RATE_CYCLES edges.
- Bounce: a glitch shorter than DEBOUNCE_CYCLES samples yields no pulse and no level change in either direction.
- Pulse width is always exactly 1 cycle. A channel never pulses in two consecutive cycles unless a rate parameter is 1.

## Configuration
- Macro TETRIS_AUTOREPEAT_EN.
- Defined: behaviour as above, with REPEAT states for right, down and left.
- Undefined: the REPEAT state and repeat counting are not built. HELD waits only for release, and every channel produces exactly one pulse per accepted press. REPEAT_* parameters are ignored.

## Structure
- Shared package `tetris_pkg`:
  - button index constants BTN_RIGHT=0, BTN_DOWN=1, BTN_LEFT=2, BTN_ROTATE=3, SW_RUN=3;
  - channel state encoding IDLE/ARM/HELD/REPEAT/REL.
- Sub-module `tetris_debounce_ch`: one channel (synchroniser, FSM, counter, pulse, level). It takes a 1-bit parameter REPEAT_ALLOW. The top instantiates it 8 times and adds the start/move gating and the left/right conflict logic.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3.
- Start: sw[3] 0→1, sampled high at edge 0 → o_start high for exactly the cycle after edge 6; o_sw_level[3]=1 from edge 6.
- Bounce: with sw[3]=1, btn[2] toggles high 3 cycles, low 1, high 3, low → no o_left pulse, o_btn_level[2] stays 0.
- Auto-repeat: btn[1] held 40 cycles → o_down pulses after edges 6, 16, 19, 22, 25, …; stops within 6 edges of release. Without macro: a single pulse at edge 6.
- Rotate: btn[3] held 40 cycles → exactly one o_rotate pulse.
- Gating and conflict: btn[0] pressed while sw[3]=0 → no o_right pulse. btn[0] and btn[2] pressed on the same edge with sw[3]=1 → neither pulse.
- Reset: assert w_reset_n low mid-REPEAT → all outputs 0 immediately. Release reset with btn held → one pulse 6 edges later.
